// File: rtl/wbu_pkg.sv
// Shared codeword layout for the wishbone-over-UART decompressor: class prefixes,
// canonical write header, decode and relative-offset helpers.
package wbu_pkg;

  localparam int CW_W = 36;

  localparam logic [2:0] CW_ADDR  = 3'b000;
  localparam logic [2:0] CW_RADDR = 3'b001;
  localparam logic [2:0] CW_CWR   = 3'b010;
  localparam logic [2:0] CW_LWR   = 3'b011;

  localparam logic [3:0] CW_WR_HDR = 4'b0110;

  typedef enum logic [2:0] {
    K_READ  = 3'd0,
    K_ADDR  = 3'd1,
    K_RADDR = 3'd2,
    K_CWR   = 3'd3,
    K_LWR   = 3'd4
  } cw_kind_e;

  // Anything with the top bit set is a read request and passes through untouched.
  function automatic cw_kind_e decode_kind(input logic [2:0] pfx);
    if (pfx[2]) return K_READ;
    case (pfx)
      CW_ADDR:  return K_ADDR;
      CW_RADDR: return K_RADDR;
      CW_CWR:   return K_CWR;
      default:  return K_LWR;
    endcase
  endfunction

  // pay is cw[30:6]; the payload is 7/13/19/25 bits wide, MSB-aligned at cw[30].
  function automatic logic [31:0] rel_offset(input logic [1:0] sel, input logic [24:0] pay);
    case (sel)
      2'd0:    return {{25{pay[24]}}, pay[24:18]};
      2'd1:    return {{19{pay[24]}}, pay[24:12]};
      2'd2:    return {{13{pay[24]}}, pay[24:6]};
      default: return {{7{pay[24]}}, pay[24:0]};
    endcase
  endfunction

endpackage

// File: rtl/wbudecomp_tbl.sv
// Write-history RAM: one write port, one registered read port, write-first bypass of the last two pushes.
// Latency: read data valid the cycle after rd_en.
// Backpressure: none; a read and a write may both occur every cycle.
module wbudecomp_tbl #(
  parameter int AW = 9,
  parameter int DW = 32
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_dat,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_dat
);

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] mem_q;

  logic [1:0]    byp_vld;
  logic [AW-1:0] byp_addr [2];
  logic [DW-1:0] byp_dat  [2];
  logic          use_byp;
  logic [DW-1:0] byp_q;

  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_addr] <= wr_dat;
    if (rd_en) mem_q <= mem[rd_addr];
  end

  // The RAM's own read-during-write value is never trusted: the newest matching push wins.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      byp_vld     <= '0;
      byp_addr[0] <= '0;
      byp_addr[1] <= '0;
      byp_dat[0]  <= '0;
      byp_dat[1]  <= '0;
      use_byp     <= 1'b0;
      byp_q       <= '0;
    end else begin
      if (wr_en) begin
        byp_vld     <= {byp_vld[0], 1'b1};
        byp_addr[1] <= byp_addr[0];
        byp_dat[1]  <= byp_dat[0];
        byp_addr[0] <= wr_addr;
        byp_dat[0]  <= wr_dat;
      end
      if (rd_en) begin
        if (wr_en && (wr_addr == rd_addr)) begin
          use_byp <= 1'b1;
          byp_q   <= wr_dat;
        end else if (byp_vld[0] && (byp_addr[0] == rd_addr)) begin
          use_byp <= 1'b1;
          byp_q   <= byp_dat[0];
        end else if (byp_vld[1] && (byp_addr[1] == rd_addr)) begin
          use_byp <= 1'b1;
          byp_q   <= byp_dat[1];
        end else begin
          use_byp <= 1'b0;
        end
      end
    end
  end

  assign rd_dat = use_byp ? byp_q : mem_q;

endmodule

// File: rtl/wbudecompress.sv
// Expands compressed address/write codewords into canonical 36-bit codewords (WBUDECOMPRESS_ERR_EN adds o_err).
// Latency: fixed 2 cycles, one codeword per clock.
// Backpressure: none; input strobes are accepted unconditionally.
module wbudecompress
  import wbu_pkg::*;
#(
  parameter int LGTBL = 9
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_stb,
  input  logic [CW_W-1:0] i_cword,
  output logic            o_stb,
  output logic [CW_W-1:0] o_cword
`ifdef WBUDECOMPRESS_ERR_EN
  ,
  output logic            o_err
`endif
);

  localparam logic [LGTBL:0] FILL_MAX = {1'b1, {LGTBL{1'b0}}};

  cw_kind_e        kind_in;
  logic [31:0]     addr_r;
  logic            inc_r;
  logic [31:0]     addr_nxt;
  logic [LGTBL-1:0] wptr;
  logic [LGTBL:0]  fill;
  logic [LGTBL-1:0] raddr_nxt;

  logic            s1_vld;
  cw_kind_e        s1_kind;
  logic [CW_W-1:0] s1_cw;
  logic [LGTBL-1:0] s1_raddr;
  logic [LGTBL-1:0] s1_waddr;
`ifdef WBUDECOMPRESS_ERR_EN
  logic            s1_err;
`endif

  logic            s2_cwr;
  logic [CW_W-1:0] s2_cw;
  logic [31:0]     tbl_dat;

  assign kind_in   = decode_kind(i_cword[35:33]);
  assign addr_nxt  = addr_r + rel_offset(i_cword[32:31], i_cword[30:6]);
  // Index 0 is the newest entry, which sits just below the write pointer.
  assign raddr_nxt = wptr - LGTBL'(1) - i_cword[24 +: LGTBL];

  // Stage 1: the address register updates here, so a following address codeword sees it next cycle.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      addr_r   <= '0;
      inc_r    <= 1'b0;
      wptr     <= '0;
      fill     <= '0;
      s1_vld   <= 1'b0;
      s1_kind  <= K_READ;
      s1_cw    <= '0;
      s1_raddr <= '0;
      s1_waddr <= '0;
`ifdef WBUDECOMPRESS_ERR_EN
      s1_err   <= 1'b0;
`endif
    end else begin
      s1_vld <= i_stb;
      if (i_stb) begin
        s1_kind  <= kind_in;
        s1_cw    <= i_cword;
        s1_raddr <= raddr_nxt;
        s1_waddr <= wptr;
`ifdef WBUDECOMPRESS_ERR_EN
        // fill never exceeds the table depth, so this also rejects out-of-range indices.
        s1_err   <= (kind_in == K_CWR) && ({1'b0, i_cword[32:24]} >= 10'(fill));
`endif
        case (kind_in)
          K_ADDR: begin
            addr_r <= i_cword[31:0];
            inc_r  <= i_cword[32];
            s1_cw  <= {CW_ADDR, i_cword[32], i_cword[31:0]};
          end
          K_RADDR: begin
            addr_r <= addr_nxt;
            s1_cw  <= {CW_ADDR, inc_r, addr_nxt};
          end
          K_LWR: begin
            wptr <= wptr + LGTBL'(1);
            if (fill != FILL_MAX) fill <= fill + (LGTBL+1)'(1);
          end
          default: ;
        endcase
      end
    end
  end

  wbudecomp_tbl #(
    .AW (LGTBL),
    .DW (32)
  ) u_tbl (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .wr_en   (s1_vld && (s1_kind == K_LWR)),
    .wr_addr (s1_waddr),
    .wr_dat  (s1_cw[31:0]),
    .rd_en   (s1_vld && (s1_kind == K_CWR)),
    .rd_addr (s1_raddr),
    .rd_dat  (tbl_dat)
  );

  // Stage 2: strobe and codeword register alongside the table's registered read.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_stb  <= 1'b0;
      s2_cwr <= 1'b0;
      s2_cw  <= '0;
`ifdef WBUDECOMPRESS_ERR_EN
      o_err  <= 1'b0;
`endif
    end else begin
`ifdef WBUDECOMPRESS_ERR_EN
      o_stb  <= s1_vld && !s1_err;
      o_err  <= s1_vld && s1_err;
`else
      o_stb  <= s1_vld;
`endif
      s2_cwr <= s1_vld && (s1_kind == K_CWR);
      if (s1_vld) s2_cw <= s1_cw;
    end
  end

  assign o_cword = s2_cwr ? {CW_WR_HDR, tbl_dat} : s2_cw;

endmodule

// File: tb/tb_wbudecompress.sv
// Scoreboard bench for wbudecompress: a behavioural model queues expected outputs with their due cycle.
module tb_wbudecompress;

  localparam int LGTBL = 9;
  localparam int DEPTH = 1 << LGTBL;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_stb;
  logic [35:0] i_cword;
  logic        o_stb;
  logic [35:0] o_cword;
`ifdef WBUDECOMPRESS_ERR_EN
  logic        o_err;
`endif

  always #5 i_clk = ~i_clk;

  wbudecompress #(.LGTBL(LGTBL)) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_stb   (i_stb),
    .i_cword (i_cword),
    .o_stb   (o_stb),
`ifdef WBUDECOMPRESS_ERR_EN
    .o_err   (o_err),
`endif
    .o_cword (o_cword)
  );

  typedef struct {
    int unsigned cyc;
    logic [35:0] cw;
    bit          err;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          tests = 0;
  int          fails = 0;
  int unsigned cyc = 0;

  logic [31:0] m_addr;
  logic        m_inc;
  logic [31:0] m_hist[$];

  always @(posedge i_clk) cyc <= cyc + 1;

  // Output side of the scoreboard.
  always @(negedge i_clk) begin
    if (!i_reset) begin
      if (o_stb) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL unexpected_stb: got cw=%h at cyc %0d, no output expected", o_cword, cyc);
        end else begin
          mon_e = sb.pop_front();
          if (mon_e.err || o_cword !== mon_e.cw || cyc !== mon_e.cyc) begin
            fails++;
            $display("FAIL scoreboard: got stb cw=%h cyc=%0d, required cw=%h cyc=%0d err=%0d",
                     o_cword, cyc, mon_e.cw, mon_e.cyc, mon_e.err);
          end
        end
      end
`ifdef WBUDECOMPRESS_ERR_EN
      if (o_err) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL unexpected_err: o_err high at cyc %0d, nothing expected", cyc);
        end else begin
          mon_e = sb.pop_front();
          if (!mon_e.err || cyc !== mon_e.cyc) begin
            fails++;
            $display("FAIL err_pulse: got err at cyc=%0d, required err=%0d cw=%h cyc=%0d",
                     cyc, mon_e.err, mon_e.cw, mon_e.cyc);
          end
        end
      end
`endif
    end
  end

  function automatic logic [35:0] mklw(input logic [31:0] d);
    return {4'b0110, d};
  endfunction

  function automatic logic [35:0] mkcw(input logic [8:0] k);
    return {3'b010, k, 24'h0};
  endfunction

  function automatic logic [35:0] mkrel(input logic [1:0] sel, input logic [30:0] pay);
    logic [35:0] c;
    int w;
    w = 7 + 6 * int'(sel);
    c = '0;
    c[35:33] = 3'b001;
    c[32:31] = sel;
    c[30:0] = (pay & ((31'd1 << w) - 31'd1)) << (31 - w);
    return c;
  endfunction

  // Drives one codeword for one clock and updates the behavioural model.
  task automatic send(input logic [35:0] cw, input bit expect_out);
    exp_t e;
    logic [31:0] p;
    int w;
    int k;
    @(posedge i_clk);
    #1;
    i_stb = 1'b1;
    i_cword = cw;
    e.cyc = cyc + 2;
    e.err = 1'b0;
    e.cw = cw;
    if (!cw[35]) begin
      case (cw[34:33])
        2'd0: begin
          m_addr = cw[31:0];
          m_inc = cw[32];
          e.cw = {3'b000, cw[32:0]};
        end
        2'd1: begin
          w = 7 + 6 * int'(cw[32:31]);
          p = 32'(cw[30:0] >> (31 - w));
          if (p[w-1]) p = p | ~((32'd1 << w) - 32'd1);
          m_addr = m_addr + p;
          e.cw = {3'b000, m_inc, m_addr};
        end
        2'd3: m_hist.push_back(cw[31:0]);
        default: begin
          k = int'(cw[32:24]);
          if (k < m_hist.size() && k < DEPTH) e.cw = {4'b0110, m_hist[m_hist.size()-1-k]};
          else e.err = 1'b1;
        end
      endcase
    end
    if (expect_out) sb.push_back(e);
  endtask

  task automatic idle();
    @(posedge i_clk);
    #1;
    i_stb = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge i_clk);
    @(negedge i_clk);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain_%s: %0d outputs still pending, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    i_stb = 1'b0;
    sb.delete();
    m_addr = '0;
    m_inc = 1'b0;
    m_hist.delete();
    repeat (2) @(posedge i_clk);
    #1;
    i_reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge i_clk);
    tests++;
    if (o_stb !== 1'b0) begin
      fails++;
      $display("FAIL reset_stb: got %b, required 0", o_stb);
    end
    tests++;
    if (o_cword !== 36'h0) begin
      fails++;
      $display("FAIL reset_cword: got %h, required 0", o_cword);
    end
  endtask

  task automatic test_address();
    send(36'h100001000, 1'b1);
    send(36'h27F000000, 1'b1);
    idle();
    drain("addr_plan");
    send(mkrel(2'd3, 31'h1000000), 1'b1);
    send(mkrel(2'd1, 31'd5), 1'b1);
    send(mkrel(2'd2, 31'h7FFFD), 1'b1);
    send(mkrel(2'd0, 31'h3F), 1'b1);
    send(36'h0FFFFFFF0, 1'b1);
    send(mkrel(2'd0, 31'h20), 1'b1);
    for (int i = 0; i < 8; i++) send(mkrel(2'($urandom_range(0, 3)), 31'($urandom)), 1'b1);
    idle();
    drain("addr_chain");
  endtask

  task automatic test_bypass();
    send(36'h612345678, 1'b1);
    send(36'h400000000, 1'b1);
    idle();
    drain("bypass_1");
    send(mklw(32'hDEADBEEF), 1'b1);
    send(mklw(32'hCAFEF00D), 1'b1);
    send(mkcw(9'd1), 1'b1);
    send(mkcw(9'd0), 1'b1);
    send(mklw(32'h01234567), 1'b1);
    send(36'h2E0000000, 1'b1);
    send(mkcw(9'd0), 1'b1);
    idle();
    drain("bypass_2");
  endtask

  task automatic test_history();
    send(mklw(32'hA), 1'b1);
    send(mklw(32'hB), 1'b1);
    send(mklw(32'hC), 1'b1);
    idle();
    repeat (3) @(posedge i_clk);
    send(mkcw(9'd2), 1'b1);
    send(mkcw(9'd0), 1'b1);
    send(mkcw(9'd1), 1'b1);
    idle();
    drain("history");
  endtask

  task automatic test_wrap();
    do_reset();
    for (int n = 0; n < DEPTH + 3; n++) send(mklw(32'(n)), 1'b1);
    send(mkcw(9'(DEPTH - 1)), 1'b1);
    send(mkcw(9'd0), 1'b1);
    idle();
    drain("wrap");
  endtask

  task automatic test_read_reset();
    bit seen;
    send(36'h2E0000000, 1'b1);
    send(36'hC87654321, 1'b1);
    idle();
    drain("read");
    send(mklw(32'h55AA55AA), 1'b0);
    send(36'h012345678, 1'b0);
    @(posedge i_clk);
    #1;
    i_reset = 1'b1;
    i_stb = 1'b0;
    seen = 1'b0;
    repeat (3) begin
      @(negedge i_clk);
      if (o_stb !== 1'b0) seen = 1'b1;
    end
    tests++;
    if (seen) begin
      fails++;
      $display("FAIL reset_inflight_stb: got o_stb=1 during reset, required 0");
    end
    do_reset();
    seen = 1'b0;
    repeat (4) begin
      @(negedge i_clk);
      if (o_stb !== 1'b0) seen = 1'b1;
    end
    tests++;
    if (seen) begin
      fails++;
      $display("FAIL reset_flush_stb: got o_stb=1 after reset, required 0");
    end
    send(36'h27F000000, 1'b1);
    idle();
    drain("post_reset_rel");
  endtask

`ifdef WBUDECOMPRESS_ERR_EN
  task automatic test_err();
    do_reset();
    send(mklw(32'h00000055), 1'b1);
    send(mkcw(9'd1), 1'b1);
    send(mkcw(9'd0), 1'b1);
    send(mkcw(9'h1FF), 1'b1);
    send(36'h2E0000000, 1'b1);
    idle();
    drain("err");
  endtask
`endif

  initial begin
    i_reset = 1'b1;
    i_stb = 1'b0;
    i_cword = '0;
    test_reset();
    test_address();
    test_bypass();
    test_history();
    test_wrap();
    test_read_reset();
`ifdef WBUDECOMPRESS_ERR_EN
    test_err();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

endmodule
